// File: rtl/argmin_pipe.sv
// Pipelined min/argmin over INPUTS unsigned words: a registered binary comparator
// tree, one tree level per enabled cycle, ties resolved toward the lower index.

module argmin_node #(
  parameter int W  = 7,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  lo_val,
  input  logic [IW-1:0] lo_idx,
  input  logic [W-1:0]  hi_val,
  input  logic [IW-1:0] hi_idx,
  output logic [W-1:0]  min_val,
  output logic [IW-1:0] min_idx
);
  // Higher lane must be strictly smaller to win, so equal costs keep the lower index.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_val <= '0;
      min_idx <= '0;
    end else if (en) begin
      if (hi_val < lo_val) begin
        min_val <= hi_val;
        min_idx <= hi_idx;
      end else begin
        min_val <= lo_val;
        min_idx <= lo_idx;
      end
    end
  end
endmodule

module argmin_pipe #(
  parameter  int WIDTH     = 7,
  parameter  int INPUTS    = 8,
  localparam int IDX_WIDTH = $clog2(INPUTS),
  localparam int LEVELS    = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic [WIDTH*INPUTS-1:0] input_words,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        min_value,
  output logic [IDX_WIDTH-1:0]    min_index
);
  localparam int LANES = 1 << LEVELS;
  localparam int NODES = 2*LANES - 1;

  // Heap-ordered tree: node i has children 2i+1 (lower lanes) and 2i+2; leaves at LANES-1+j.
  logic [NODES-1:0][WIDTH-1:0]     t_val;
  logic [NODES-1:0][IDX_WIDTH-1:0] t_idx;
  logic [LEVELS-1:0]               vld_pipe;
  logic                            root_en;

  if (LEVELS == 1) begin : g_vld1
    assign root_en = ce & in_valid;
    always_ff @(posedge clk) begin
      if (rst)     vld_pipe <= '0;
      else if (ce) vld_pipe <= in_valid;
    end
  end else begin : g_vldn
    assign root_en = ce & vld_pipe[LEVELS-2];
    always_ff @(posedge clk) begin
      if (rst)     vld_pipe <= '0;
      else if (ce) vld_pipe <= {vld_pipe[LEVELS-2:0], in_valid};
    end
  end

  // Pad lanes carry all-ones and their own index, so any real lane beats them.
  for (genvar j = 0; j < LANES; j++) begin : g_leaf
    if (j < INPUTS) begin : g_real
      assign t_val[LANES-1+j] = input_words[j*WIDTH +: WIDTH];
    end else begin : g_pad
      assign t_val[LANES-1+j] = '1;
    end
    assign t_idx[LANES-1+j] = IDX_WIDTH'(j);
  end

  // The root doubles as the output register and only loads with a valid result.
  for (genvar i = 0; i < LANES-1; i++) begin : g_node
    argmin_node #(.W(WIDTH), .IW(IDX_WIDTH)) u_node (
      .clk     (clk),
      .rst     (rst),
      .en      ((i == 0) ? root_en : ce),
      .lo_val  (t_val[2*i+1]),
      .lo_idx  (t_idx[2*i+1]),
      .hi_val  (t_val[2*i+2]),
      .hi_idx  (t_idx[2*i+2]),
      .min_val (t_val[i]),
      .min_idx (t_idx[i])
    );
  end

  assign out_valid = vld_pipe[LEVELS-1];
  assign min_value = t_val[0];
  assign min_index = t_idx[0];
endmodule

// File: tb/tb_argmin_pipe.sv
// Directed vectors for INPUTS=8/5 plus randomised scoreboards for INPUTS in {2,3,8,13}.
module tb_argmin_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic in_valid = 1'b0;
  logic [55:0] w8 = '0;
  logic [34:0] w5 = '0;
  logic ov8, ov5;
  logic [6:0] mv8, mv5;
  logic [2:0] mi8, mi5;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  argmin_pipe #(.WIDTH(7), .INPUTS(8)) d8 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .input_words(w8),
    .out_valid(ov8), .min_value(mv8), .min_index(mi8));
  argmin_pipe #(.WIDTH(7), .INPUTS(5)) d5 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .input_words(w5),
    .out_valid(ov5), .min_value(mv5), .min_index(mi5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {7'(a7), 7'(a6), 7'(a5), 7'(a4), 7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  task automatic chk8(input string tag, input int v, input int vl, input int ix);
    chk({tag, "_ov"}, 32'(ov8), 32'(v));
    if (v != 0) begin
      chk({tag, "_val"}, 32'(mv8), 32'(vl));
      chk({tag, "_idx"}, 32'(mi8), 32'(ix));
    end
  endtask

  // Random-phase DUTs, each with a plain linear-scan scoreboard and enabled-cycle latency check.
  for (genvar g = 0; g < 4; g++) begin : r
    localparam int N = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 8 : 13;
    localparam int L = $clog2(N);
    logic [7*N-1:0] words = '0;
    logic ov;
    logic [6:0] mv;
    logic [L-1:0] mi;
    int qv[$], qi[$], qc[$];
    int en_cnt = 0;

    argmin_pipe #(.WIDTH(7), .INPUTS(N)) dut (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .input_words(words),
      .out_valid(ov), .min_value(mv), .min_index(mi));

    always @(posedge clk) begin
      bit pop;
      int mn, arg;
      pop = 1'b0;
      if (rst) begin
        qv.delete(); qi.delete(); qc.delete();
      end else if (ce) begin
        if (in_valid) begin
          mn = 128; arg = 0;
          for (int i = 0; i < N; i++)
            if (int'(words[i*7 +: 7]) < mn) begin mn = int'(words[i*7 +: 7]); arg = i; end
          qv.push_back(mn); qi.push_back(arg); qc.push_back(en_cnt);
        end
        en_cnt++;
        pop = 1'b1;
      end
      #1;
      if (pop && ov) begin
        chk($sformatf("r%0d_pending", N), 32'(qv.size() > 0), 32'd1);
        if (qv.size() > 0) begin
          chk($sformatf("r%0d_val", N), 32'(mv), 32'(qv.pop_front()));
          chk($sformatf("r%0d_idx", N), 32'(mi), 32'(qi.pop_front()));
          chk($sformatf("r%0d_lat", N), 32'(en_cnt - qc.pop_front()), 32'(L));
        end
      end
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       words[i*7 +: 7] = '1;
          1:       words[i*7 +: 7] = 7'($urandom_range(0, 3));
          default: words[i*7 +: 7] = 7'($urandom);
        endcase
      end
    end
  end

  initial begin
    // reset state
    tick(); tick();
    chk8("rst", 0, 0, 0);
    chk("rst_val", 32'(mv8), 32'd0);
    chk("rst_idx", 32'(mi8), 32'd0);
    rst = 1'b0;
    tick();

    // single vector, latency 3
    w8 = p8(1, 2, 3, 4, 5, 6, 7, 8); in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk8("single_c1", 0, 0, 0); tick();
    chk8("single_c2", 0, 0, 0); tick();
    chk8("single_c3", 1, 1, 0); tick();
    chk8("single_c4", 0, 0, 0);

    // back-to-back, incl. all-equal tie
    w8 = p8(13, 5, 19, 100, 0, 1, 1, 127); in_valid = 1'b1; tick();
    w8 = p8(100, 100, 100, 100, 100, 100, 100, 100); tick();
    w8 = p8(127, 55, 8, 100, 99, 12, 100, 3); tick();
    in_valid = 1'b0;
    chk8("b2b_a", 1, 0, 4); tick();
    chk8("b2b_tie", 1, 100, 0); tick();
    chk8("b2b_c", 1, 3, 7); tick();
    chk8("b2b_end", 0, 0, 0);

    // INPUTS=5, pad lanes must never win
    w5 = {7'd127, 7'd127, 7'd127, 7'd127, 7'd127}; in_valid = 1'b1; tick();
    w5 = {7'd126, 7'd127, 7'd127, 7'd127, 7'd127}; tick();
    in_valid = 1'b0; tick();
    chk("pad_ov", 32'(ov5), 32'd1);
    chk("pad_val", 32'(mv5), 32'd127);
    chk("pad_idx", 32'(mi5), 32'd0);
    tick();
    chk("last_ov", 32'(ov5), 32'd1);
    chk("last_val", 32'(mv5), 32'd126);
    chk("last_idx", 32'(mi5), 32'd4);
    tick();
    chk("n5_end_ov", 32'(ov5), 32'd0);

    // stall: earlier result held, new one appears 7 clocks after injection
    w8 = p8(50, 40, 30, 20, 10, 60, 70, 80); in_valid = 1'b1; tick();
    w8 = p8(9, 8, 7, 6, 5, 4, 3, 2); tick();
    in_valid = 1'b0; tick();
    chk8("pre_stall", 1, 10, 4);
    ce = 1'b0;
    w8 = p8(0, 0, 0, 0, 0, 0, 0, 0); in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk8($sformatf("stall%0d", k), 1, 10, 4);
    end
    ce = 1'b1; in_valid = 1'b0; tick();
    chk8("post_stall", 1, 2, 7); tick();
    chk8("post_stall_end", 0, 0, 0);

    // reset mid-flight discards both vectors
    w8 = p8(3, 3, 3, 3, 3, 3, 3, 3); in_valid = 1'b1; tick();
    w8 = p8(5, 6, 7, 8, 9, 10, 11, 1); tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk8("mid_rst", 0, 0, 0);
    chk("mid_rst_val", 32'(mv8), 32'd0);
    chk("mid_rst_idx", 32'(mi8), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk8($sformatf("mid_rst_q%0d", k), 0, 0, 0);
    end
    w8 = p8(4, 4, 1, 1, 4, 4, 4, 4); in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk8("after_rst_c2", 0, 0, 0); tick();
    chk8("after_rst_c3", 1, 1, 2);

    // random in_valid / ce
    for (int k = 0; k < 2500; k++) begin
      ce = ($urandom_range(0, 9) < 8);
      in_valid = ($urandom_range(0, 9) < 7);
      w8 = {$urandom, $urandom};
      tick();
    end
    ce = 1'b1; in_valid = 1'b0;
    repeat (20) tick();
    chk("drain2", 32'(r[0].qv.size()), 32'd0);
    chk("drain3", 32'(r[1].qv.size()), 32'd0);
    chk("drain8", 32'(r[2].qv.size()), 32'd0);
    chk("drain13", 32'(r[3].qv.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
